// File: rtl/alu_shift_right_seq.sv
// alu_shift_right_seq: iterative SRL/SRA unit for RV32I, shifting STEP bits per cycle.
// Handshake: operands accepted on in_valid & in_ready (IDLE only); the result is presented
// on out/out_valid and held until out_ready.
// Optional feature: define ALU_SHIFT_FLUSH_EN to add a synchronous flush input that
// kills any in-flight operation (branch-mispredict kill).
module alu_shift_right_seq #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [4:0]      shamt,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            busy
`ifdef ALU_SHIFT_FLUSH_EN
  ,
  input  logic            flush
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // STEP as a 5-bit amount; legal values (1..16) all fit.
  localparam logic [4:0] STEP_AMT = 5'(STEP);

  state_t          state_r, state_s;
  logic [XLEN-1:0] acc_r, acc_s;
  logic [4:0]      remaining_r, remaining_s;
  logic            fill_r, fill_s;
  logic [XLEN-1:0] out_s;
  logic [4:0]      k_s;
  logic [XLEN-1:0] shifted_s;
  logic            flush_s;
  logic            unused_funct7_s;

  // Only funct7[5] selects arithmetic vs logical; the remaining bits are don't-care.
  assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

`ifdef ALU_SHIFT_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Right shift by k with the vacated top bits set to the fill value.
  function automatic logic [XLEN-1:0] shr_fill(input logic [XLEN-1:0] v,
                                               input logic [4:0]      k,
                                               input logic            f);
    logic [XLEN-1:0] r;
    if (f) begin
      r = ~((~v) >> k);
    end else begin
      r = v >> k;
    end
    return r;
  endfunction

  // Handshake flags are pure decodes of the state register.
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);

  // Per-cycle shift amount: STEP, clamped to what is left so we never overshoot shamt.
  always_comb begin
    k_s       = (remaining_r > STEP_AMT) ? STEP_AMT : remaining_r;
    shifted_s = shr_fill(acc_r, k_s, fill_r);
  end

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    remaining_s = remaining_r;
    fill_s      = fill_r;
    out_s       = out;
    case (state_r)
      IDLE: begin
        if (flush_s) begin
          state_s = IDLE;
        end else if (in_valid) begin
          acc_s       = a;
          remaining_s = shamt;
          fill_s      = funct7[5] & a[XLEN-1];
          if (shamt == 5'd0) begin
            state_s = DONE;
            out_s   = a;
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (flush_s) begin
          state_s = IDLE;
        end else begin
          acc_s       = shifted_s;
          remaining_s = remaining_r - k_s;
          // Last shift step: the result goes straight into the output register.
          if (remaining_r <= k_s) begin
            state_s = DONE;
            out_s   = shifted_s;
          end else begin
            state_s = SHIFT;
          end
        end
      end
      DONE: begin
        if (flush_s) begin
          state_s = IDLE;
        end else if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      acc_r       <= {XLEN{1'b0}};
      remaining_r <= 5'd0;
      fill_r      <= 1'b0;
      out         <= {XLEN{1'b0}};
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      remaining_r <= remaining_s;
      fill_r      <= fill_s;
      out         <= out_s;
    end
  end

endmodule

// File: tb/tb_alu_shift_right_seq.sv
// Directed bench for alu_shift_right_seq: two instances (STEP=1 and STEP=4) share the
// input stimulus; results, latencies, backpressure and mid-op reset are checked.
module tb_alu_shift_right_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic [6:0]  funct7;
  logic        out_ready;

  logic        in_ready1, out_valid1, busy1;
  logic [31:0] out1;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] out4;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  sh;
    logic [6:0]  f7;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  alu_shift_right_seq #(.XLEN(32), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .shamt(shamt), .funct7(funct7), .out_valid(out_valid1),
    .out_ready(out_ready), .out(out1), .busy(busy1)
  );

  alu_shift_right_seq #(.XLEN(32), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .shamt(shamt), .funct7(funct7), .out_valid(out_valid4),
    .out_ready(out_ready), .out(out4), .busy(busy4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op to both instances, then track when each raises out_valid.
  task automatic run_op(input vec_t v, input string name);
    int lat1, lat4, exp1, exp4;
    logic [31:0] o1, o4;
    lat1 = 0; lat4 = 0; o1 = 32'h0; o4 = 32'h0;
    exp1 = 1 + int'(v.sh);
    exp4 = 1 + (int'(v.sh) + 3) / 4;
    @(negedge clk);
    in_valid = 1'b1; a = v.a; shamt = v.sh; funct7 = v.f7; out_ready = 1'b1;
    @(posedge clk);
    #1;
    // Scramble operands after accept: they must have no effect.
    in_valid = 1'b0; a = ~v.a; shamt = ~v.sh; funct7 = ~v.f7;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      if (out_valid1 && lat1 == 0) begin lat1 = c; o1 = out1; end
      if (out_valid4 && lat4 == 0) begin lat4 = c; o4 = out4; end
      if (lat1 != 0 && lat4 != 0) break;
    end
    chk({name, "_out_s1"}, o1, v.exp);
    chk({name, "_lat_s1"}, 32'(lat1), 32'(exp1));
    chk({name, "_out_s4"}, o4, v.exp);
    chk({name, "_lat_s4"}, 32'(lat4), 32'(exp4));
    @(posedge clk);
    #1;
    chk({name, "_idle"}, {30'd0, busy1, busy4}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h80000000, 5'd4,  7'h20, 32'hF8000000};
    vecs[1]  = '{32'h80000000, 5'd4,  7'h00, 32'h08000000};
    vecs[2]  = '{32'h12345678, 5'd0,  7'h00, 32'h12345678};
    vecs[3]  = '{32'h80000001, 5'd31, 7'h20, 32'hFFFFFFFF};
    vecs[4]  = '{32'h80000001, 5'd31, 7'h00, 32'h00000001};
    vecs[5]  = '{32'h7FFFFFFF, 5'd31, 7'h20, 32'h00000000};
    vecs[6]  = '{32'hF0F0F0F0, 5'd8,  7'h20, 32'hFFF0F0F0};
    vecs[7]  = '{32'hF0F0F0F0, 5'd8,  7'h00, 32'h00F0F0F0};
    vecs[8]  = '{32'hDEADBEEF, 5'd5,  7'h7F, 32'hFEF56DF7};
    vecs[9]  = '{32'hDEADBEEF, 5'd5,  7'h5F, 32'h06F56DF7};
    vecs[10] = '{32'h80000000, 5'd16, 7'h20, 32'hFFFF8000};
    vecs[11] = '{32'hAAAAAAAA, 5'd3,  7'h00, 32'h15555555};

    rst_n = 1'b0; in_valid = 1'b0; a = 32'h0; shamt = 5'd0; funct7 = 7'h0; out_ready = 1'b0;
    #12;
    chk("rst_flags_s1", {29'd0, in_ready1, out_valid1, busy1}, 32'h4);
    chk("rst_out_s1", out1, 32'h0);
    chk("rst_flags_s4", {29'd0, in_ready4, out_valid4, busy4}, 32'h4);
    chk("rst_out_s4", out4, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result must hold while out_ready is low; new in_valid is ignored.
    begin
      int seen;
      seen = 0;
      @(negedge clk);
      in_valid = 1'b1; a = 32'h80000000; shamt = 5'd2; funct7 = 7'h20; out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
        if (out_valid1) begin seen = 1; break; end
        @(posedge clk);
        #1;
      end
      chk("bp_seen", 32'(seen), 32'd1);
      chk("bp_out", out1, 32'hE0000000);
      for (int c = 0; c < 3; c++) begin
        in_valid = 1'b1; a = 32'h12345678; shamt = 5'd0; funct7 = 7'h00;
        @(posedge clk);
        #1;
        chk("bp_hold_flags", {29'd0, in_ready1, out_valid1, busy1}, 32'h3);
        chk("bp_hold_out_s1", out1, 32'hE0000000);
        chk("bp_hold_out_s4", out4, 32'hE0000000);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release", {28'd0, out_valid1, out_valid4, in_ready1, in_ready4}, 32'h3);
      @(posedge clk);
      #1;
      chk("bp_no_queue", {30'd0, busy1, busy4}, 32'd0);
    end

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    in_valid = 1'b1; a = 32'hF0000000; shamt = 5'd20; funct7 = 7'h00; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", {30'd0, busy1, busy4}, 32'h3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flags_s1", {29'd0, in_ready1, out_valid1, busy1}, 32'h4);
    chk("mid_rst_out_s1", out1, 32'h0);
    chk("mid_rst_flags_s4", {29'd0, in_ready4, out_valid4, busy4}, 32'h4);
    chk("mid_rst_out_s4", out4, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(vecs[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
